// File: rtl/fp_normalize_pkg.sv
// Shared widths, limits and FSM encoding for the floating-point normalizer.
package fp_pkg;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int MANT_W = 23;
  localparam int SUM_W  = 25;
  localparam int EXP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/fp_normalize_if.sv
// Raw-result input and normalized-result output bundle of the normalizer.
interface fp_normalize_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  raw_sum;
  logic [EXP_W-1:0]  raw_exponent;
  logic              raw_sign;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  final_sum;
  logic [EXP_W-1:0]  final_exponent;
  logic              new_sign;
  logic              overflow_exc;
  logic              underflow_exc;

  modport slave (
    input  in_valid, raw_sum, raw_exponent, raw_sign, out_ready,
    output in_ready, out_valid, final_sum, final_exponent, new_sign,
           overflow_exc, underflow_exc
  );

  modport master (
    output in_valid, raw_sum, raw_exponent, raw_sign, out_ready,
    input  in_ready, out_valid, final_sum, final_exponent, new_sign,
           overflow_exc, underflow_exc
  );
endinterface

// File: rtl/fp_normalize.sv
// Iterative mantissa normalizer: one right shift for carry, or one left shift
// per cycle until the hidden bit is set or the exponent bottoms out.
module fp_normalize
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fp_normalize_if.slave bus
);

  state_t           state, state_nx;
  logic [SUM_W-1:0] sum, sum_nx;
  logic [EXP_W:0]   expo, expo_nx;    // extra bit keeps +1/-1 from wrapping
  logic             sign, sign_nx;
  logic             ovf, ovf_nx;
  logic             unf, unf_nx;
  logic [4:0]       cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      expo <= '0;
      sign <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      cnt  <= '0;
    end else begin
      sum  <= sum_nx;
      expo <= expo_nx;
      sign <= sign_nx;
      ovf  <= ovf_nx;
      unf  <= unf_nx;
      cnt  <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sum_nx   = sum;
    expo_nx  = expo;
    sign_nx  = sign;
    ovf_nx   = ovf;
    unf_nx   = unf;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (bus.in_valid) begin
        sum_nx   = bus.raw_sum;
        expo_nx  = {1'b0, bus.raw_exponent};
        sign_nx  = bus.raw_sign;
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        cnt_nx   = '0;
        state_nx = NORM;
      end
      NORM: begin
        if (expo == {1'b0, EXP_MAX}) begin
          ovf_nx   = 1'b1;
          state_nx = HOLD;
        end else if (sum == '0) begin
          expo_nx  = '0;
          state_nx = HOLD;
        end else if (sum[SUM_W-1]) begin
          sum_nx   = sum >> 1;
          expo_nx  = expo + 9'd1;
          ovf_nx   = (expo + 9'd1) == {1'b0, EXP_MAX};
          state_nx = HOLD;
        end else if (sum[MANT_W]) begin
          state_nx = HOLD;
        end else if (expo == '0) begin
          unf_nx   = 1'b1;
          state_nx = HOLD;
        end else if (cnt == 5'(MANT_W)) begin
          // backstop: a nonzero sum reaches the hidden bit within MANT_W shifts
          state_nx = HOLD;
        end else begin
          sum_nx   = sum << 1;
          expo_nx  = expo - 9'd1;
          cnt_nx   = cnt + 5'd1;
        end
      end
      HOLD: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready       = (state == IDLE);
  assign bus.out_valid      = (state == HOLD);
  assign bus.final_sum      = sum;
  assign bus.final_exponent = expo[EXP_W-1:0];
  assign bus.new_sign       = sign;
  assign bus.overflow_exc   = ovf;
  assign bus.underflow_exc  = unf;

endmodule
